// File: rtl/srec_emitter_if.sv
// Handshake and bus bundle for the S-record emitter: dump control,
// byte-read memory port and the outgoing ASCII character stream.
interface srec_emitter_if;
  logic        start;
  logic [31:0] start_address;
  logic [31:0] byte_count;
  logic [31:0] entry_address;
  logic        busy;
  logic        done;
  logic [31:0] read_address;
  logic        read_enable;
  logic [7:0]  read_data;
  logic [7:0]  char_data;
  logic        char_valid;
  logic        char_ready;

  // emitter side
  modport master (
    input  start, start_address, byte_count, entry_address, read_data, char_ready,
    output busy, done, read_address, read_enable, char_data, char_valid
  );

  // controller / memory / UART side
  modport slave (
    output start, start_address, byte_count, entry_address, read_data, char_ready,
    input  busy, done, read_address, read_enable, char_data, char_valid
  );
endinterface

// File: rtl/srec_emitter.sv
// Streams a memory region as Motorola S3 records followed by an S7
// terminator, one ASCII character per valid/ready transfer.
module srec_emitter #(
  parameter int BYTES_PER_RECORD = 16
) (
  input  logic clock,
  input  logic reset,
  srec_emitter_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, HDR_S, HDR_TYPE, COUNT_HI, COUNT_LO, ADDR, FETCH, WAIT_DATA,
    DATA_HI, DATA_LO, SUM_HI, SUM_LO, CR, LF, DONE
  } state_t;

  state_t      state;
  logic [31:0] addr;       // next data byte address
  logic [31:0] remaining;  // data bytes not yet emitted
  logic [31:0] entry;
  logic [31:0] hdr;        // address field, shifted out a nibble at a time
  logic [7:0]  count_r;
  logic [7:0]  left_n;     // data bytes left in the current record
  logic [7:0]  sum;
  logic [7:0]  data_r;
  logic [2:0]  nib;
  logic        is_s7;

  function automatic logic [7:0] hex(input logic [3:0] v);
    return (v < 4'd10) ? 8'h30 + {4'h0, v} : 8'h37 + {4'h0, v};
  endfunction

  // Next-record setup, evaluated from registers when the 'S' is accepted.
  logic        xfer;
  logic        last_rec;
  logic [7:0]  rec_n;
  logic [7:0]  rec_cnt;
  logic [31:0] rec_addr;
  logic [7:0]  rec_sum;
  logic [7:0]  csum;

  assign xfer     = bus.char_valid & bus.char_ready;
  assign last_rec = (remaining == 32'd0);
  assign rec_n    = (remaining > 32'(BYTES_PER_RECORD)) ? 8'(BYTES_PER_RECORD) : remaining[7:0];
  assign rec_cnt  = last_rec ? 8'd5 : rec_n + 8'd5;
  assign rec_addr = last_rec ? entry : addr;
  assign rec_sum  = rec_cnt + rec_addr[31:24] + rec_addr[23:16] + rec_addr[15:8] + rec_addr[7:0];
  assign csum     = ~sum;

  // Record sequencer: every output is registered and set on entry to a state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      addr             <= '0;
      remaining        <= '0;
      entry            <= '0;
      hdr              <= '0;
      count_r          <= '0;
      left_n           <= '0;
      sum              <= '0;
      data_r           <= '0;
      nib              <= '0;
      is_s7            <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.read_address <= '0;
      bus.read_enable  <= 1'b0;
      bus.char_data    <= '0;
      bus.char_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          addr           <= bus.start_address;
          remaining      <= bus.byte_count;
          entry          <= bus.entry_address;
          bus.busy       <= 1'b1;
          bus.char_data  <= "S";
          bus.char_valid <= 1'b1;
          state          <= HDR_S;
        end
        HDR_S: if (xfer) begin
          is_s7         <= last_rec;
          count_r       <= rec_cnt;
          hdr           <= rec_addr;
          sum           <= rec_sum;
          left_n        <= rec_n;
          bus.char_data <= last_rec ? "7" : "3";
          state         <= HDR_TYPE;
        end
        HDR_TYPE: if (xfer) begin
          bus.char_data <= hex(count_r[7:4]);
          state         <= COUNT_HI;
        end
        COUNT_HI: if (xfer) begin
          bus.char_data <= hex(count_r[3:0]);
          state         <= COUNT_LO;
        end
        COUNT_LO: if (xfer) begin
          bus.char_data <= hex(hdr[31:28]);
          nib           <= '0;
          state         <= ADDR;
        end
        ADDR: if (xfer) begin
          if (nib == 3'd7) begin
            if (is_s7) begin
              bus.char_data <= hex(csum[7:4]);
              state         <= SUM_HI;
            end else begin
              bus.char_valid   <= 1'b0;
              bus.read_enable  <= 1'b1;
              bus.read_address <= addr;
              state            <= FETCH;
            end
          end else begin
            hdr           <= hdr << 4;
            bus.char_data <= hex(hdr[27:24]);
            nib           <= nib + 3'd1;
          end
        end
        FETCH: begin
          bus.read_enable <= 1'b0;
          state           <= WAIT_DATA;
        end
        WAIT_DATA: begin
          data_r         <= bus.read_data;
          sum            <= sum + bus.read_data;
          bus.char_data  <= hex(bus.read_data[7:4]);
          bus.char_valid <= 1'b1;
          state          <= DATA_HI;
        end
        DATA_HI: if (xfer) begin
          bus.char_data <= hex(data_r[3:0]);
          state         <= DATA_LO;
        end
        DATA_LO: if (xfer) begin
          addr      <= addr + 32'd1;
          remaining <= remaining - 32'd1;
          left_n    <= left_n - 8'd1;
          if (left_n == 8'd1) begin
            bus.char_data <= hex(csum[7:4]);
            state         <= SUM_HI;
          end else begin
            bus.char_valid   <= 1'b0;
            bus.read_enable  <= 1'b1;
            bus.read_address <= addr + 32'd1;
            state            <= FETCH;
          end
        end
        SUM_HI: if (xfer) begin
          bus.char_data <= hex(csum[3:0]);
          state         <= SUM_LO;
        end
        SUM_LO: if (xfer) begin
          bus.char_data <= 8'h0D;
          state         <= CR;
        end
        CR: if (xfer) begin
          bus.char_data <= 8'h0A;
          state         <= LF;
        end
        LF: if (xfer) begin
          if (is_s7) begin
            bus.char_valid <= 1'b0;
            bus.done       <= 1'b1;
            state          <= DONE;
          end else begin
            bus.char_data <= "S";
            state         <= HDR_S;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_srec_emitter.sv
// Directed bench for srec_emitter: table of dumps with hand-computed
// S-record text, plus stall, ignored-start and mid-dump reset sequences.
module tb_srec_emitter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  srec_emitter_if bus();
  srec_emitter #(.BYTES_PER_RECORD(16)) dut (.clock(clock), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  string       got;
  logic [31:0] reads[$];
  int          dones;

  typedef struct {
    logic [31:0] sa;
    logic [31:0] bc;
    logic [31:0] ea;
    int          stall;   // char index to stall at, -1 for none
    string       exp;
  } vec_t;

  function automatic logic [7:0] mem(input logic [31:0] a);
    if (a == 32'h100) return 8'h12;
    if (a == 32'h101) return 8'h34;
    return a[7:0];
  endfunction

  // memory model and stream monitor
  always @(posedge clock) begin
    if (bus.read_enable) begin
      bus.read_data <= mem(bus.read_address);
      reads.push_back(bus.read_address);
    end
    if (bus.char_valid && bus.char_ready) got = {got, $sformatf("%c", bus.char_data)};
    if (bus.done) dones++;
  end

  task automatic check(input string name, input logic ok, input string detail);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  task automatic run(input vec_t v, input string tag);
    logic [7:0] held;
    int         stalls;
    logic       finished;
    logic       stall_ok;
    logic       order_ok;
    got = ""; reads.delete(); dones = 0;
    stalls = 0; finished = 1'b0; stall_ok = 1'b1; held = '0;
    @(negedge clock);
    bus.start = 1'b1;
    bus.start_address = v.sa; bus.byte_count = v.bc; bus.entry_address = v.ea;
    @(negedge clock);
    bus.start = 1'b0;
    check({tag, "_busy"}, bus.busy === 1'b1, $sformatf("busy=%b want 1", bus.busy));
    for (int cyc = 0; cyc < 3000; cyc++) begin
      // a second start mid-dump with different operands must be ignored
      bus.start = (cyc == 5);
      if (cyc == 5) begin
        bus.start_address = 32'hDEAD0000; bus.byte_count = 32'd5; bus.entry_address = 32'h55;
      end
      if (v.stall >= 0 && got.len() == v.stall && bus.char_valid && stalls < 5) begin
        if (stalls == 0) held = bus.char_data;
        else if (bus.char_data !== held || bus.char_valid !== 1'b1) stall_ok = 1'b0;
        if (bus.read_enable !== 1'b0) stall_ok = 1'b0;
        bus.char_ready = 1'b0;
        stalls++;
      end else begin
        bus.char_ready = 1'b1;
      end
      @(negedge clock);
      if (!bus.busy) begin finished = 1'b1; break; end
    end
    bus.start = 1'b0;
    bus.char_ready = 1'b1;
    check({tag, "_finish"}, finished, "dump did not finish within 3000 cycles");
    if (v.stall >= 0)
      check({tag, "_stall"}, stall_ok && stalls == 5,
            $sformatf("held/quiet=%b stalls=%0d want held, 5", stall_ok, stalls));
    check({tag, "_text"}, got == v.exp, $sformatf("got \"%s\" want \"%s\"", got, v.exp));
    check({tag, "_nreads"}, reads.size() == int'(v.bc),
          $sformatf("reads=%0d want %0d", reads.size(), v.bc));
    order_ok = 1'b1;
    foreach (reads[i]) if (reads[i] !== v.sa + 32'(i)) order_ok = 1'b0;
    check({tag, "_raddr"}, order_ok, "read addresses not sequential from start_address");
    check({tag, "_done"}, dones == 1, $sformatf("done pulses=%0d want 1", dones));
  endtask

  initial begin
    string crlf;
    vec_t  vecs[6];
    int    waited;
    crlf = "\015\012";
    vecs[0] = '{32'h100, 32'd2, 32'h0, -1,
                {"S307000001001234B1", crlf, "S70500000000FA", crlf}};
    vecs[1] = '{32'h100, 32'd2, 32'h0, 12,
                {"S307000001001234B1", crlf, "S70500000000FA", crlf}};
    vecs[2] = '{32'h0, 32'd0, 32'h80000000, -1, {"S705800000007A", crlf}};
    vecs[3] = '{32'h2000, 32'd17, 32'h0, -1,
                {"S31500002000000102030405060708090A0B0C0D0E0F52", crlf,
                 "S3060000201010B9", crlf, "S70500000000FA", crlf}};
    vecs[4] = '{32'hFFFFFFFF, 32'd2, 32'h0, -1,
                {"S307FFFFFFFFFF00FD", crlf, "S70500000000FA", crlf}};
    vecs[5] = '{32'h30, 32'd1, 32'h12345678, -1,
                {"S306000000303099", crlf, "S70512345678E6", crlf}};

    bus.start = 1'b0; bus.start_address = '0; bus.byte_count = '0;
    bus.entry_address = '0; bus.char_ready = 1'b1; bus.read_data = '0;

    repeat (3) @(negedge clock);
    check("reset_state",
          bus.busy === 1'b0 && bus.done === 1'b0 && bus.char_valid === 1'b0 &&
          bus.read_enable === 1'b0 && bus.char_data === 8'h00 && bus.read_address === 32'h0,
          $sformatf("busy=%b done=%b cv=%b re=%b cd=%h ra=%h want all 0",
                    bus.busy, bus.done, bus.char_valid, bus.read_enable,
                    bus.char_data, bus.read_address));
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 6; i++) run(vecs[i], $sformatf("vec%0d", i));

    // reset in the middle of the address field, then a clean dump
    got = "";
    @(negedge clock);
    bus.start = 1'b1; bus.start_address = 32'h100; bus.byte_count = 32'd2; bus.entry_address = 32'h0;
    @(negedge clock);
    bus.start = 1'b0;
    waited = 0;
    while (got.len() < 6 && waited < 100) begin @(negedge clock); waited++; end
    check("mid_reset_reach", got.len() >= 6, $sformatf("chars=%0d want >=6", got.len()));
    reset = 1'b1;
    #1;
    check("mid_reset_outputs",
          bus.char_valid === 1'b0 && bus.busy === 1'b0 && bus.done === 1'b0,
          $sformatf("cv=%b busy=%b done=%b want 0 0 0", bus.char_valid, bus.busy, bus.done));
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    run(vecs[0], "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
